stopwatch_controller: RTL and testbench

- Central control FSM for the stopwatch; sits between the per-button edge detectors and the time counter/display path.
- Consumes 2-bit edge codes for the start/stop and lap buttons and sequences run, pause, lap-freeze and clear.
- Generates the count-enable tick from the system clock via an internal prescaler.
- Long-press on start/stop while paused clears the time.

---
 rtl/stopwatch_controller.sv | 141 ++++++++++++++
 tb/tb_stopwatch_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM: sequences run/pause/lap/clear from button edge codes
// and derives the count-enable tick from clk through a prescaler.
module stopwatch_controller #(
   parameter int TICK_DIV    = 100000,
   parameter int PRESCALE_W  = 17,
   parameter int HOLD_CYCLES = 100000000,
   parameter int HOLD_W      = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] ss_edge,
   input  logic [1:0] lap_edge,
   output logic       count_en,
   output logic       count_clr,
   output logic       display_freeze,
   output logic [1:0] state
);

   // state | meaning
   // IDLE  | time cleared, waiting for start
   // RUN   | counting, display live
   // PAUSE | counting halted; long start/stop press or lap press clears
   // LAP   | counting, display frozen on the lap value
   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_LAP   = 2'b11
   } state_t;

   localparam logic [PRESCALE_W-1:0] TICK_LAST = PRESCALE_W'(TICK_DIV - 1);
   localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   state_t                state_q, state_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic [HOLD_W-1:0]     hold_q, hold_d;
   logic                  hold_armed_q, hold_armed_d;
   logic                  clr_done_q, clr_done_d;
   logic                  count_en_q, count_en_d;
   logic                  count_clr_q, count_clr_d;
   logic                  freeze_q, freeze_d;
   logic                  do_clear;

   logic ss_press, ss_rel, lap_press, ss_rel_live;
   assign ss_press    = (ss_edge == 2'b01);
   assign ss_rel      = (ss_edge == 2'b10);
   assign lap_press   = (lap_edge == 2'b01);
   // The release following a long-press clear must not restart the watch.
   assign ss_rel_live = ss_rel && !clr_done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         presc_q      <= '0;
         hold_q       <= '0;
         hold_armed_q <= 1'b0;
         clr_done_q   <= 1'b0;
         count_en_q   <= 1'b0;
         count_clr_q  <= 1'b0;
         freeze_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         hold_q       <= hold_d;
         hold_armed_q <= hold_armed_d;
         clr_done_q   <= clr_done_d;
         count_en_q   <= count_en_d;
         count_clr_q  <= count_clr_d;
         freeze_q     <= freeze_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      presc_d      = presc_q;
      hold_d       = hold_q;
      hold_armed_d = hold_armed_q;
      clr_done_d   = clr_done_q;
      count_en_d   = 1'b0;
      count_clr_d  = 1'b0;
      do_clear     = 1'b0;

      if (ss_press || ss_rel) clr_done_d = 1'b0;

      if (state_q == S_RUN || state_q == S_LAP) begin
         if (presc_q == TICK_LAST) begin
            presc_d    = '0;
            count_en_d = 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (ss_press) state_d = S_RUN;
         end
         S_RUN: begin
            if (ss_press)       state_d = S_PAUSE;
            else if (lap_press) state_d = S_LAP;
         end
         S_LAP: begin
            if (ss_press)       state_d = S_PAUSE;
            else if (lap_press) state_d = S_RUN;
         end
         S_PAUSE: begin
            if (ss_press) begin
               hold_armed_d = 1'b1;
               hold_d       = '0;
            end else if (hold_armed_q && ss_rel_live) begin
               state_d      = S_RUN;
               hold_armed_d = 1'b0;
            end else if (hold_armed_q && hold_q == HOLD_LAST) begin
               do_clear   = 1'b1;
               clr_done_d = 1'b1;
            end else if (lap_press) begin
               do_clear = 1'b1;
            end else if (hold_armed_q) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (do_clear) begin
         state_d      = S_IDLE;
         presc_d      = '0;
         hold_d       = '0;
         hold_armed_d = 1'b0;
         count_clr_d  = 1'b1;
      end

      freeze_d = (state_d == S_LAP);
   end

   assign count_en       = count_en_q;
   assign count_clr      = count_clr_q;
   assign display_freeze = freeze_q;
   assign state          = state_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller: table vectors, directed corner sequences and
// randomized stimulus against a cycle-count reference model.
module tb_stopwatch_controller;

   localparam int TICK = 4;
   localparam int HOLD = 8;
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;
   localparam logic [1:0] ST_LAP   = 2'b11;

   logic       clk;
   logic       rst;
   logic [1:0] ss_edge;
   logic [1:0] lap_edge;
   logic       count_en;
   logic       count_clr;
   logic       display_freeze;
   logic [1:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   stopwatch_controller #(
      .TICK_DIV(TICK), .PRESCALE_W(17), .HOLD_CYCLES(HOLD), .HOLD_W(27)
   ) dut (
      .clk(clk), .rst(rst), .ss_edge(ss_edge), .lap_edge(lap_edge),
      .count_en(count_en), .count_clr(count_clr),
      .display_freeze(display_freeze), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: running time is the number of clocks spent counting since
   // the last clear; a tick fires whenever that total is a multiple of TICK.
   // A hold clears once HOLD clocks have passed since the arming press.
   logic [1:0] m_state;
   int         m_elapsed;
   int         m_arm_cyc;
   int         m_cyc = 0;
   logic       e_en, e_clr, e_frz;

   function automatic void model_reset();
      m_state   = ST_IDLE;
      m_elapsed = 0;
      m_arm_cyc = -1;
      e_en = 1'b0; e_clr = 1'b0; e_frz = 1'b0;
   endfunction

   function automatic void model_step(input logic [1:0] ss, input logic [1:0] lap);
      bit press = (ss == 2'b01);
      bit rel   = (ss == 2'b10);
      bit lp    = (lap == 2'b01);
      bit clear = 1'b0;
      logic [1:0] ns = m_state;
      m_cyc++;
      e_en = 1'b0;
      if (m_state == ST_RUN || m_state == ST_LAP) begin
         m_elapsed++;
         e_en = ((m_elapsed % TICK) == 0);
      end
      case (m_state)
         ST_IDLE:  if (press) ns = ST_RUN;
         ST_RUN:   if (press) ns = ST_PAUSE; else if (lp) ns = ST_LAP;
         ST_LAP:   if (press) ns = ST_PAUSE; else if (lp) ns = ST_RUN;
         default: begin
            if (press) m_arm_cyc = m_cyc;
            else if (m_arm_cyc >= 0 && rel) begin
               ns = ST_RUN;
               m_arm_cyc = -1;
            end else if (m_arm_cyc >= 0 && (m_cyc - m_arm_cyc) == HOLD) clear = 1'b1;
            else if (lp) clear = 1'b1;
         end
      endcase
      if (clear) begin
         ns        = ST_IDLE;
         m_elapsed = 0;
         m_arm_cyc = -1;
      end
      e_clr   = clear;
      e_frz   = (ns == ST_LAP);
      m_state = ns;
   endfunction

   task automatic check_outputs(input string name);
      n_checks++;
      if ({state, count_en, count_clr, display_freeze} !== {m_state, e_en, e_clr, e_frz}) begin
         n_fail++;
         $display("FAIL %s @%0t: got state=%b en=%b clr=%b frz=%b, expected state=%b en=%b clr=%b frz=%b",
                  name, $time, state, count_en, count_clr, display_freeze, m_state, e_en, e_clr, e_frz);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic step(input logic [1:0] ss, input logic [1:0] lap, input string name);
      ss_edge  = ss;
      lap_edge = lap;
      @(posedge clk);
      model_step(ss, lap);
      @(negedge clk);
      check_outputs(name);
   endtask

   task automatic do_reset();
      ss_edge  = 2'b00;
      lap_edge = 2'b00;
      #2 rst = 1'b1;
      #1 model_reset();
      check_outputs("reset_async");
      @(posedge clk);
      @(negedge clk);
      check_outputs("reset_held");
      rst = 1'b0;
   endtask

   typedef struct {
      logic [1:0] ss;
      logic [1:0] lap;
      logic [1:0] st;
      logic       en;
      logic       clr;
      logic       frz;
   } vec_t;

   vec_t vecs[18];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses, first, last, bad_gap, k, n;
      logic [1:0] rs, rl;
      int r;

      vecs[0]  = '{2'b00, 2'b01, ST_IDLE,  1'b0, 1'b0, 1'b0};
      vecs[1]  = '{2'b10, 2'b00, ST_IDLE,  1'b0, 1'b0, 1'b0};
      vecs[2]  = '{2'b11, 2'b11, ST_IDLE,  1'b0, 1'b0, 1'b0};
      vecs[3]  = '{2'b01, 2'b01, ST_RUN,   1'b0, 1'b0, 1'b0};
      vecs[4]  = '{2'b00, 2'b00, ST_RUN,   1'b0, 1'b0, 1'b0};
      vecs[5]  = '{2'b00, 2'b01, ST_LAP,   1'b0, 1'b0, 1'b1};
      vecs[6]  = '{2'b00, 2'b00, ST_LAP,   1'b0, 1'b0, 1'b1};
      vecs[7]  = '{2'b00, 2'b00, ST_LAP,   1'b1, 1'b0, 1'b1};
      vecs[8]  = '{2'b00, 2'b01, ST_RUN,   1'b0, 1'b0, 1'b0};
      vecs[9]  = '{2'b01, 2'b01, ST_PAUSE, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{2'b10, 2'b00, ST_PAUSE, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{2'b01, 2'b00, ST_PAUSE, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{2'b10, 2'b00, ST_RUN,   1'b0, 1'b0, 1'b0};
      vecs[13] = '{2'b00, 2'b00, ST_RUN,   1'b0, 1'b0, 1'b0};
      vecs[14] = '{2'b00, 2'b00, ST_RUN,   1'b1, 1'b0, 1'b0};
      vecs[15] = '{2'b01, 2'b00, ST_PAUSE, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{2'b00, 2'b01, ST_IDLE,  1'b0, 1'b1, 1'b0};
      vecs[17] = '{2'b00, 2'b00, ST_IDLE,  1'b0, 1'b0, 1'b0};

      rst = 1'b1; ss_edge = 2'b00; lap_edge = 2'b00;
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs("power_on_reset");
      rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         ss_edge  = vecs[i].ss;
         lap_edge = vecs[i].lap;
         @(posedge clk);
         model_step(vecs[i].ss, vecs[i].lap);
         @(negedge clk);
         n_checks++;
         if ({state, count_en, count_clr, display_freeze} !==
             {vecs[i].st, vecs[i].en, vecs[i].clr, vecs[i].frz}) begin
            n_fail++;
            $display("FAIL vec%0d: got state=%b en=%b clr=%b frz=%b, expected state=%b en=%b clr=%b frz=%b",
                     i, state, count_en, count_clr, display_freeze,
                     vecs[i].st, vecs[i].en, vecs[i].clr, vecs[i].frz);
         end
      end

      // ticking: 5 pulses in 20 running cycles, 4 apart
      step(2'b01, 2'b00, "tick_start");
      pulses = 0; first = -1; last = -1; bad_gap = 0;
      for (int i = 1; i <= 20; i++) begin
         step(2'b00, 2'b00, "tick_run");
         if (count_en) begin
            pulses++;
            if (first < 0) first = i;
            else if (i - last != TICK) bad_gap++;
            last = i;
         end
      end
      chk_int("tick_count", pulses, 5);
      chk_int("tick_first", first, 4);
      chk_int("tick_spacing", bad_gap, 0);

      // pause preserves prescaler phase
      repeat (5) step(2'b00, 2'b00, "phase_run");
      step(2'b01, 2'b00, "phase_pause");
      chk_int("phase_state_pause", int'(state), int'(ST_PAUSE));
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step(2'b00, 2'b00, "phase_paused");
         if (count_en) n++;
      end
      chk_int("pause_no_tick", n, 0);
      step(2'b01, 2'b00, "short_press");
      step(2'b00, 2'b00, "short_hold");
      step(2'b10, 2'b00, "short_release");
      chk_int("resume_state", int'(state), int'(ST_RUN));
      k = 0;
      for (int i = 1; i <= 10 && k == 0; i++) begin
         step(2'b00, 2'b00, "resume_run");
         if (count_en) k = i;
      end
      chk_int("resume_phase", k, 2);

      // lap freeze with continued counting, then ss+lap together
      step(2'b00, 2'b01, "lap_enter");
      chk_int("lap_freeze", int'(display_freeze), 1);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         step(2'b00, 2'b00, "lap_run");
         if (count_en) n++;
      end
      chk_int("lap_ticks", n, 2);
      step(2'b00, 2'b01, "lap_exit");
      step(2'b01, 2'b01, "ss_lap_same");
      chk_int("ss_wins_state", int'(state), int'(ST_PAUSE));

      // long-press clear, consumed release, lap clear
      step(2'b10, 2'b00, "pause_release_ignored");
      step(2'b01, 2'b00, "long_press");
      k = 0;
      for (int i = 1; i <= 20 && k == 0; i++) begin
         step(2'b00, 2'b00, "long_hold");
         if (count_clr) k = i;
      end
      chk_int("long_clear_delay", k, HOLD);
      chk_int("long_clear_state", int'(state), int'(ST_IDLE));
      step(2'b00, 2'b00, "long_after");
      chk_int("clear_single_pulse", int'(count_clr), 0);
      step(2'b10, 2'b00, "long_release");
      chk_int("release_consumed", int'(state), int'(ST_IDLE));
      step(2'b01, 2'b00, "lapclr_run");
      step(2'b01, 2'b00, "lapclr_pause");
      step(2'b00, 2'b01, "lapclr_clear");
      chk_int("lap_clear_pulse", int'(count_clr), 1);

      // async reset mid-run
      step(2'b01, 2'b00, "rst_run");
      repeat (3) step(2'b00, 2'b00, "rst_running");
      do_reset();
      step(2'b01, 2'b00, "rst_restart");
      chk_int("restart_state", int'(state), int'(ST_RUN));

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            r = $urandom_range(0, 99);
            rs = (r < 60) ? 2'b00 : (r < 72) ? 2'b01 : (r < 84) ? 2'b10 : 2'b11;
            r = $urandom_range(0, 99);
            rl = (r < 85) ? 2'b00 : (r < 93) ? 2'b01 : (r < 97) ? 2'b10 : 2'b11;
            step(rs, rl, "random");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
